// File: rtl/apuf_pkg.sv
// rtl/apuf_pkg.sv - shared FSM state type and LFSR tap table for the arbiter PUF key generator
package apuf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DISCHARGE,
        LAUNCH,
        SETTLE_W,
        SAMPLE,
        NEXT,
        DONE
    } apuf_state_e;

    // One-hot bit for 1-based tap position n (0 means "no tap").
    function automatic logic [63:0] bitp(input int n);
        return (n > 0) ? (64'd1 << (n - 1)) : 64'd0;
    endfunction

    // Maximal-length tap sets for widths 8..64, bit (t-1) set for every tap t.
    // Used as the XOR mask of a right-shifting Galois LFSR.
    function automatic logic [63:0] lfsr_taps(input int width);
        logic [63:0] m;
        case (width)
            8:  m = bitp(8)  | bitp(6)  | bitp(5)  | bitp(4);
            9:  m = bitp(9)  | bitp(5);
            10: m = bitp(10) | bitp(7);
            11: m = bitp(11) | bitp(9);
            12: m = bitp(12) | bitp(6)  | bitp(4)  | bitp(1);
            13: m = bitp(13) | bitp(4)  | bitp(3)  | bitp(1);
            14: m = bitp(14) | bitp(5)  | bitp(3)  | bitp(1);
            15: m = bitp(15) | bitp(14);
            16: m = bitp(16) | bitp(15) | bitp(13) | bitp(4);
            17: m = bitp(17) | bitp(14);
            18: m = bitp(18) | bitp(11);
            19: m = bitp(19) | bitp(6)  | bitp(2)  | bitp(1);
            20: m = bitp(20) | bitp(17);
            21: m = bitp(21) | bitp(19);
            22: m = bitp(22) | bitp(21);
            23: m = bitp(23) | bitp(18);
            24: m = bitp(24) | bitp(23) | bitp(22) | bitp(17);
            25: m = bitp(25) | bitp(22);
            26: m = bitp(26) | bitp(6)  | bitp(2)  | bitp(1);
            27: m = bitp(27) | bitp(5)  | bitp(2)  | bitp(1);
            28: m = bitp(28) | bitp(25);
            29: m = bitp(29) | bitp(27);
            30: m = bitp(30) | bitp(6)  | bitp(4)  | bitp(1);
            31: m = bitp(31) | bitp(28);
            32: m = bitp(32) | bitp(22) | bitp(2)  | bitp(1);
            33: m = bitp(33) | bitp(20);
            34: m = bitp(34) | bitp(27) | bitp(2)  | bitp(1);
            35: m = bitp(35) | bitp(33);
            36: m = bitp(36) | bitp(25);
            37: m = bitp(37) | bitp(5)  | bitp(4)  | bitp(3) | bitp(2) | bitp(1);
            38: m = bitp(38) | bitp(6)  | bitp(5)  | bitp(1);
            39: m = bitp(39) | bitp(35);
            40: m = bitp(40) | bitp(38) | bitp(21) | bitp(19);
            41: m = bitp(41) | bitp(38);
            42: m = bitp(42) | bitp(41) | bitp(20) | bitp(19);
            43: m = bitp(43) | bitp(42) | bitp(38) | bitp(37);
            44: m = bitp(44) | bitp(43) | bitp(18) | bitp(17);
            45: m = bitp(45) | bitp(44) | bitp(42) | bitp(41);
            46: m = bitp(46) | bitp(45) | bitp(26) | bitp(25);
            47: m = bitp(47) | bitp(42);
            48: m = bitp(48) | bitp(47) | bitp(21) | bitp(20);
            49: m = bitp(49) | bitp(40);
            50: m = bitp(50) | bitp(49) | bitp(24) | bitp(23);
            51: m = bitp(51) | bitp(50) | bitp(36) | bitp(35);
            52: m = bitp(52) | bitp(49);
            53: m = bitp(53) | bitp(52) | bitp(38) | bitp(37);
            54: m = bitp(54) | bitp(53) | bitp(18) | bitp(17);
            55: m = bitp(55) | bitp(31);
            56: m = bitp(56) | bitp(55) | bitp(35) | bitp(34);
            57: m = bitp(57) | bitp(50);
            58: m = bitp(58) | bitp(39);
            59: m = bitp(59) | bitp(58) | bitp(38) | bitp(37);
            60: m = bitp(60) | bitp(59);
            61: m = bitp(61) | bitp(60) | bitp(46) | bitp(45);
            62: m = bitp(62) | bitp(61) | bitp(6)  | bitp(5);
            63: m = bitp(63) | bitp(62);
            64: m = bitp(64) | bitp(63) | bitp(61) | bitp(60);
            default: m = bitp(width) | bitp(width - 1);
        endcase
        return m;
    endfunction

endpackage

// File: rtl/apuf_chain.sv
// rtl/apuf_chain.sv - one switch-mux arbiter chain with arbiter latch
//
// Ports:
//   clk, rst   - clock / sync reset (used by the simulation model only)
//   launch     - rising edge races down both paths of the chain
//   challenge  - one select bit per mux stage
//   clr        - clears the arbiter latch before the next launch
//   out        - arbiter decision (1 = top path arrived first)
module apuf_chain #(
    parameter int STAGES   = 16,
    parameter int CHAIN_ID = 0,
    parameter bit NOISY    = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              launch,
    input  logic [STAGES-1:0] challenge,
    input  logic              clr,
    output logic              out
);

`ifndef SYNTHESIS
    // Deterministic stand-in for the silicon race: parity of the challenge
    // xored with the chain id, or a fixed 5-vote flicker pattern for a chain
    // marked noisy (votes 1,0,1,1,0 -> bit i of the pattern is vote i).
    localparam logic [STAGES-1:0] ID_MASK       = STAGES'(CHAIN_ID);
    localparam logic [4:0]        NOISE_PATTERN = 5'b01101;

    logic       arb_q;
    logic [2:0] vote_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            arb_q  <= 1'b0;
            vote_q <= 3'd0;
        end else if (clr) begin
            arb_q  <= 1'b0;
        end else if (launch) begin
            arb_q  <= NOISY ? NOISE_PATTERN[vote_q] : ^(challenge ^ ID_MASK);
            vote_q <= (vote_q == 3'd4) ? 3'd0 : vote_q + 3'd1;
        end
    end

    assign out = arb_q;
`else
    (* dont_touch = "true" *) logic [STAGES:0] top_w;
    (* dont_touch = "true" *) logic [STAGES:0] bot_w;
    (* dont_touch = "true" *) logic            arb_q;

    assign top_w[0] = launch;
    assign bot_w[0] = launch;

    // Each stage either passes both edges straight through or swaps them.
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        assign top_w[i+1] = challenge[i] ? bot_w[i] : top_w[i];
        assign bot_w[i+1] = challenge[i] ? top_w[i] : bot_w[i];
    end

    // Arbiter: the bottom edge clocks in the top path; a 1 means top won.
    always_ff @(posedge bot_w[STAGES] or posedge clr) begin
        if (clr) arb_q <= 1'b0;
        else     arb_q <= top_w[STAGES];
    end

    assign out = arb_q;
`endif

endmodule

// File: rtl/arbiter_puf_keygen.sv
// rtl/arbiter_puf_keygen.sv - majority-voted key generation from a bank of arbiter PUF chains
//
// Ports:
//   clk          - single clock
//   reset        - synchronous active-high reset
//   start        - request one key generation (accepted only when idle)
//   seed         - initial challenge, sampled on the accepted start
//   busy         - high in every state except IDLE
//   done         - one-cycle pulse when response/unstable_cnt are valid
//   response     - majority-voted key bits
//   unstable_cnt - number of bits whose votes were not unanimous
module arbiter_puf_keygen
    import apuf_pkg::*;
#(
    parameter int STAGES          = 16,
    parameter int CHAINS          = 4,
    parameter int VOTES           = 5,
    parameter int RESP_BITS       = 32,
    parameter int SETTLE          = 4,
    parameter int SIM_NOISY_CHAIN = -1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [STAGES-1:0]              seed,
    output logic                           busy,
    output logic                           done,
    output logic [RESP_BITS-1:0]           response,
    output logic [$clog2(RESP_BITS+1)-1:0] unstable_cnt
);

    localparam int IW = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam int CW = (CHAINS > 1) ? $clog2(CHAINS) : 1;
    localparam int VW = $clog2(VOTES + 1);
    localparam int SW = $clog2(SETTLE + 1);
    localparam int UW = $clog2(RESP_BITS + 1);

    localparam logic [63:0]       TAPS_ALL = lfsr_taps(STAGES);
    localparam logic [STAGES-1:0] TAPS     = TAPS_ALL[STAGES-1:0];

    apuf_state_e          state_q, state_d;
    logic [STAGES-1:0]    lfsr_q, lfsr_d;
    logic [IW-1:0]        bit_q, bit_d;
    logic [CW-1:0]        sel_q, sel_d;       // bit index mod CHAINS, kept as its own counter
    logic [VW-1:0]        vote_q, vote_d;
    logic [VW-1:0]        ones_q, ones_d;
    logic [SW-1:0]        settle_q, settle_d;
    logic [RESP_BITS-1:0] resp_q, resp_d;
    logic [UW-1:0]        unst_q, unst_d;

    logic [CHAINS-1:0]    chain_out;
    logic [CHAINS-1:0]    launch_vec;
    logic                 chain_clr;
    logic                 sel_out;

    // Launch lines are decoded straight from state, so reset gates them to
    // keep every line low in the reset cycle itself.
    always_comb begin
        launch_vec = '0;
        if (state_q == LAUNCH && !reset) launch_vec[sel_q] = 1'b1;
    end

    assign chain_clr = (state_q == DISCHARGE) || reset;
    assign sel_out   = chain_out[sel_q];

    for (genvar g = 0; g < CHAINS; g++) begin : g_chain
        (* dont_touch = "true" *)
        apuf_chain #(
            .STAGES   (STAGES),
            .CHAIN_ID (g),
            .NOISY    (g == SIM_NOISY_CHAIN)
        ) u_chain (
            .clk       (clk),
            .rst       (reset),
            .launch    (launch_vec[g]),
            .challenge (lfsr_q),
            .clr       (chain_clr),
            .out       (chain_out[g])
        );
    end

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        bit_d    = bit_q;
        sel_d    = sel_q;
        vote_d   = vote_q;
        ones_d   = ones_q;
        settle_d = settle_q;
        resp_d   = resp_q;
        unst_d   = unst_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // An all-zero seed would lock the LFSR, so substitute all-ones.
                    lfsr_d  = (seed == '0) ? '1 : seed;
                    bit_d   = '0;
                    sel_d   = '0;
                    vote_d  = '0;
                    ones_d  = '0;
                    resp_d  = '0;
                    unst_d  = '0;
                    state_d = DISCHARGE;
                end
            end
            DISCHARGE: state_d = LAUNCH;
            LAUNCH: begin
                settle_d = '0;
                state_d  = SETTLE_W;
            end
            SETTLE_W: begin
                if (settle_q == SW'(SETTLE - 1)) state_d = SAMPLE;
                else settle_d = settle_q + 1'b1;
            end
            SAMPLE: begin
                ones_d = ones_q + VW'(sel_out);
                if (vote_q == VW'(VOTES - 1)) begin
                    vote_d  = '0;
                    state_d = NEXT;
                end else begin
                    vote_d  = vote_q + 1'b1;
                    state_d = DISCHARGE;
                end
            end
            NEXT: begin
                resp_d[bit_q] = (ones_q > VW'(VOTES / 2));
                if (ones_q != '0 && ones_q != VW'(VOTES)) unst_d = unst_q + 1'b1;
                lfsr_d = {1'b0, lfsr_q[STAGES-1:1]} ^ (lfsr_q[0] ? TAPS : '0);
                ones_d = '0;
                if (bit_q == IW'(RESP_BITS - 1)) begin
                    state_d = DONE;
                end else begin
                    bit_d   = bit_q + 1'b1;
                    sel_d   = (sel_q == CW'(CHAINS - 1)) ? '0 : sel_q + 1'b1;
                    state_d = DISCHARGE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            lfsr_q   <= '1;
            bit_q    <= '0;
            sel_q    <= '0;
            vote_q   <= '0;
            ones_q   <= '0;
            settle_q <= '0;
            resp_q   <= '0;
            unst_q   <= '0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            bit_q    <= bit_d;
            sel_q    <= sel_d;
            vote_q   <= vote_d;
            ones_q   <= ones_d;
            settle_q <= settle_d;
            resp_q   <= resp_d;
            unst_q   <= unst_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign response     = resp_q;
    assign unstable_cnt = unst_q;

endmodule

// File: tb/tb_arbiter_puf_keygen.sv
// tb/tb_arbiter_puf_keygen.sv - scoreboard bench for arbiter_puf_keygen
module tb_arbiter_puf_keygen;

    localparam int ST  = 16;
    localparam int CH  = 4;
    localparam int V   = 5;
    localparam int RB  = 32;
    localparam int S   = 4;
    localparam int LAT = RB * (V * (S + 3) + 1) + 1;
    // Galois mask for x^16 + x^15 + x^13 + x^4 + 1 (taps 16,15,13,4).
    localparam logic [15:0] POLY = 16'hD008;

    typedef struct {
        logic [31:0] resp;
        int          unst;
        longint      scyc;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          start;
    logic [ST-1:0] seed;
    logic          busy_a, done_a, busy_b, done_b;
    logic [RB-1:0] resp_a, resp_b;
    logic [5:0]    unst_a, unst_b;

    int     n_pass = 0;
    int     n_total = 0;
    longint cyc = 0;
    int     done_cnt_a = 0;
    int     noise_pat [5] = '{1, 0, 1, 1, 0};
    exp_t   q_a[$];
    exp_t   q_b[$];

    arbiter_puf_keygen #(.STAGES(ST), .CHAINS(CH), .VOTES(V), .RESP_BITS(RB), .SETTLE(S),
                         .SIM_NOISY_CHAIN(-1)) dut_a (
        .clk(clk), .reset(reset), .start(start), .seed(seed),
        .busy(busy_a), .done(done_a), .response(resp_a), .unstable_cnt(unst_a)
    );

    arbiter_puf_keygen #(.STAGES(ST), .CHAINS(CH), .VOTES(V), .RESP_BITS(RB), .SETTLE(S),
                         .SIM_NOISY_CHAIN(2)) dut_b (
        .clk(clk), .reset(reset), .start(start), .seed(seed),
        .busy(busy_b), .done(done_b), .response(resp_b), .unstable_cnt(unst_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference key: walk the challenge sequence, vote each bit from its chain.
    function automatic logic [31:0] ref_key(input logic [15:0] sd, input bit noisy, output int unst);
        logic [15:0] c;
        logic [31:0] r;
        int          ones;
        c    = (sd == 16'h0) ? 16'hFFFF : sd;
        r    = '0;
        unst = 0;
        for (int b = 0; b < RB; b++) begin
            int chn;
            chn  = b % CH;
            ones = 0;
            for (int v = 0; v < V; v++) begin
                if (noisy && chn == 2) ones += noise_pat[v];
                else ones += int'(^(c ^ 16'(chn)));
            end
            r[b] = (ones > V / 2);
            if (ones != 0 && ones != V) unst++;
            c = (c >> 1) ^ (c[0] ? POLY : 16'h0);
        end
        return r;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (done_a) begin
                if (q_a.size() == 0) begin
                    check("a_unexpected_done", 1, 0);
                end else begin
                    e = q_a.pop_front();
                    check("a_response", resp_a, e.resp);
                    check("a_unstable_cnt", unst_a, e.unst);
                    check("a_latency", cyc - e.scyc, LAT);
                    check("a_busy_in_done", busy_a, 1);
                    done_cnt_a++;
                end
            end
            if (done_b) begin
                if (q_b.size() == 0) begin
                    check("b_unexpected_done", 1, 0);
                end else begin
                    e = q_b.pop_front();
                    check("b_response", resp_b, e.resp);
                    check("b_unstable_cnt", unst_b, e.unst);
                end
            end
        end
    end

    task automatic start_run(input logic [15:0] sd, input int hold);
        exp_t e;
        int   u;
        @(negedge clk);
        seed   = sd;
        start  = 1'b1;
        e.scyc = cyc;
        e.resp = ref_key(sd, 1'b0, u);
        e.unst = u;
        q_a.push_back(e);
        e.resp = ref_key(sd, 1'b1, u);
        e.unst = u;
        q_b.push_back(e);
        repeat (hold) @(negedge clk);
        start = 1'b0;
        seed  = 16'($urandom);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("run_completed", q_a.size() + q_b.size(), 0);
        @(negedge clk);
        check("idle_after_done", busy_a, 0);
    endtask

    task automatic abort_queues();
        q_a.delete();
        q_b.delete();
    endtask

    initial begin : stim
        int d0;
        reset = 1'b1;
        start = 1'b0;
        seed  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_response", resp_a, 0);
        check("rst_unstable", unst_a, 0);
        check("rst_lfsr", dut_a.lfsr_q, 16'hFFFF);
        reset = 1'b0;
        @(negedge clk);

        // Reference seed; noisy instance should give 8 unstable bits.
        start_run(16'hACE1, 1);
        check("busy_after_start", busy_a, 1);
        wait_done();

        // Zero seed falls back to all-ones.
        start_run(16'h0000, 1);
        check("zero_seed_lfsr", dut_a.lfsr_q, 16'hFFFF);
        wait_done();

        for (int i = 0; i < 3; i++) begin
            start_run(16'($urandom), int'($urandom_range(1, 3)));
            wait_done();
        end

        // Reset at cycle 500 of a run aborts it with no done pulse.
        start_run(16'($urandom), 1);
        repeat (499) @(negedge clk);
        reset = 1'b1;
        abort_queues();
        @(negedge clk);
        check("abort_busy", busy_a, 0);
        check("abort_response", resp_a, 0);
        check("abort_unstable", unst_a, 0);
        check("abort_done", done_a, 0);
        reset = 1'b0;
        repeat (1300) @(negedge clk);
        check("abort_stays_idle", busy_a, 0);
        start_run(16'($urandom), 1);
        wait_done();

        // Start while busy is ignored: exactly one done per accepted run.
        d0 = done_cnt_a;
        start_run(16'($urandom), 1);
        repeat (100) @(negedge clk);
        seed  = 16'($urandom);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        check("single_done", done_cnt_a - d0, 1);

        // Reset and start together while busy: reset wins.
        start_run(16'($urandom), 1);
        repeat (300) @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        abort_queues();
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check("rst_start_busy", busy_a, 0);
        @(negedge clk);
        check("rst_start_idle", busy_a, 0);

        // Reset and start together while idle: reset wins.
        reset = 1'b1;
        start = 1'b1;
        seed  = 16'h1234;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rst_start_idle2", busy_a, 0);
        repeat (1300) @(negedge clk);
        check("no_stray_run", busy_a, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
